// File: rtl/hex_disp_mux.sv
// hex_disp_mux: scanned, double-buffered hex driver for common-anode 7-segment digits.
// Define HEX_DISP_MUX_DP_EN to add the double-buffered decimal-point mask and dp output.
module hex_disp_mux #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
`ifdef HEX_DISP_MUX_DP_EN
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  dp,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [4*DIGITS-1:0] r_pend, r_shadow;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [FW-1:0]       r_fcnt;
  logic                r_phase, r_frame;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                w_slot_end, w_frame_end, w_fwrap, w_win, w_lz, w_blink;
  logic [3:0]          w_nib;
  assign w_slot_end  = r_cnt == CW'(SCAN_DIV - 1);
  assign w_frame_end = w_slot_end && r_idx == IW'(DIGITS - 1);
  assign w_fwrap     = r_fcnt == FW'(BLINK_DIV - 1);
  assign w_win       = r_cnt >= CW'(BLANK_CYC);
  assign w_blink     = blink_mask[r_idx] && r_phase;
  // z accumulates "all nibbles from the top down to i are zero"; digit 0 is never checked
  always_comb begin : sel
    logic z;
    z     = 1'b1;
    w_lz  = 1'b0;
    w_nib = r_shadow[3:0];
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z && (r_shadow[4*i +: 4] == 4'h0);
      if (r_idx == IW'(i)) begin
        w_lz  = z;
        w_nib = r_shadow[4*i +: 4];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_fcnt   <= '0;
      r_phase  <= 1'b0;
      r_frame  <= 1'b0;
      r_seg    <= 7'h7F;
      r_an     <= '1;
    end else begin
      if (load) r_pend <= data;
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) r_idx <= r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
      r_frame <= w_frame_end;
      if (w_frame_end) begin
        r_shadow <= r_pend;
        r_fcnt   <= w_fwrap ? '0 : r_fcnt + 1'b1;
        if (w_fwrap) r_phase <= ~r_phase;
      end
      r_an  <= w_win ? ~(DIGITS'(1) << r_idx) : '1;
      r_seg <= (!w_win || (blank_lz && w_lz) || w_blink) ? 7'h7F : GLYPH[w_nib];
    end
  end
  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;
`ifdef HEX_DISP_MUX_DP_EN
  logic [DIGITS-1:0] r_dp_pend, r_dp_shadow;
  logic              r_dp;
  // dp follows blink blanking but ignores leading-zero blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_pend   <= '0;
      r_dp_shadow <= '0;
      r_dp        <= 1'b1;
    end else begin
      if (load) r_dp_pend <= dp_mask;
      if (w_frame_end) r_dp_shadow <= r_dp_pend;
      r_dp <= !(w_win && r_dp_shadow[r_idx] && !w_blink);
    end
  end
  assign dp = r_dp;
`endif
endmodule

// File: tb/tb_hex_disp_mux.sv
// tb_hex_disp_mux: table-driven frame checks with a queue scoreboard for hex_disp_mux.
module tb_hex_disp_mux;
  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic fr;} exp_t;
  typedef struct {logic [15:0] d; logic lz; logic [27:0] g;} vec_t;
  logic        clk = 1'b0, rst_n = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame;
`ifdef HEX_DISP_MUX_DP_EN
  logic        dp;
`endif
  int          errors = 0, checks = 0, nfr = 0;
  exp_t        q[$];
  vec_t        tbl[9];
  localparam logic [27:0] G12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] G0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] G3456 = {7'h30, 7'h19, 7'h12, 7'h02};
  hex_disp_mux #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .blank_lz(blank_lz),
    .blink_mask(blink_mask),
`ifdef HEX_DISP_MUX_DP_EN
    .dp_mask(4'h0), .dp(dp),
`endif
    .seg(seg), .an(an), .frame(frame)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic wait_frame();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = frame;
    end
    chk("wait_frame", {31'b0, ok}, 32'd1);
    nfr++;
  endtask
  // Called on the negedge where frame is high; checks the 16 outputs of the new frame
  task automatic check_frame(input logic [27:0] g, input int ld_at, input logic [15:0] ld_val);
    exp_t e;
    logic ph;
    ph = nfr[1];
    for (int d = 0; d < 4; d++) begin
      q.push_back({4'hF, 7'h7F, 1'b0});
      for (int j = 0; j < 3; j++)
        q.push_back({~(4'b1 << d), (blink_mask[d] && ph) ? 7'h7F : g[7*d +: 7], d == 3 && j == 2});
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("frame%0d_slot%0d {an,seg,frame}", nfr, i), {20'b0, an, seg, frame}, {20'b0, e});
      if (i == ld_at) begin
        data = ld_val;
        load = 1'b1;
      end else if (i == ld_at + 1) load = 1'b0;
    end
    nfr++;
  endtask
  initial begin
    int k;
    tbl[0] = '{16'h12AF, 1'b0, G12AF};
    tbl[1] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    tbl[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[3] = '{16'h0000, 1'b0, G0000};
    tbl[4] = '{16'h0BCD, 1'b1, {7'h7F, 7'h03, 7'h46, 7'h21}};
    tbl[5] = '{16'h8E07, 1'b1, {7'h00, 7'h06, 7'h40, 7'h78}};
    tbl[6] = '{16'h3456, 1'b0, G3456};
    tbl[7] = '{16'h0009, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h10}};
    tbl[8] = '{16'h1000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}};
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_seg", {25'b0, seg}, 32'h7F);
    chk("reset_an", {28'b0, an}, 32'hF);
    chk("reset_frame", {31'b0, frame}, 32'd0);
    rst_n = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (frame) break;
    end
    chk("first_frame_cycle", k, 16);
    @(negedge clk);
    nfr = 1;
    for (int v = 0; v < 9; v++) begin
      data = tbl[v].d;
      blank_lz = tbl[v].lz;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame();
      check_frame(tbl[v].g, -1, 16'h0);
    end
    blank_lz = 1'b0;
    data = 16'h12AF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    check_frame(G12AF, 5, 16'h0000);
    check_frame(G0000, -1, 16'h0);
    check_frame(G0000, 14, 16'h3456);
    check_frame(G0000, -1, 16'h0);
    check_frame(G3456, -1, 16'h0);
    blink_mask = 4'b0001;
    repeat (5) check_frame(G3456, -1, 16'h0);
    blink_mask = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {25'b0, seg}, 32'h7F);
    chk("async_rst_an", {28'b0, an}, 32'hF);
    chk("async_rst_frame", {31'b0, frame}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nfr = 0;
    wait_frame();
    check_frame(G0000, -1, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hex_disp_mux.md
Name: hex_disp_mux

Overview:
- Time-multiplexed driver for a row of common-anode 7-segment digits that share one segment bus.
- Displays a DIGITS-wide hex value with optional leading-zero blanking and per-digit blink.
- Double-buffers the input so a frame never shows a mix of old and new data.
- Sits between datapath registers and the board's digit-enable and segment pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 1000, clock cycles each digit slot lasts (>= 2).
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off for anti-ghosting (< SCAN_DIV).
- BLINK_DIV, 64, full frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- data  in  4*DIGITS  hex value; nibble i drives digit i (digit 0 = rightmost).
- load  in  1  one-cycle strobe; captures data into the pending register.
- blank_lz  in  1  1 = blank leading zero digits.
- blink_mask  in  DIGITS  bit i = 1 makes digit i blink.
- seg  out  7  segments, active low; seg[0]=a .. seg[6]=g.
- an  out  DIGITS  digit enables, active low, at most one low at a time.
- frame  out  1  one-cycle pulse when the shadow register updates.

Behaviour:
- Reset (async, rst_n=0): seg=7'h7F, an=all 1s, frame=0. Pending, shadow, digit index, scan counter, frame counter and blink phase are all 0.
- Pending register:
  - Loads data on any clk edge with load=1.
  - Back-to-back loads: the last one wins.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, the digit index advances; index DIGITS-1 wraps to 0.
- Frame end: scan counter wraps while index=DIGITS-1. On that edge:
  - shadow <= pending, using pending's value before the edge. A load in the same cycle appears in the following frame.
  - frame pulses high for the next cycle.
  - The frame counter advances. When it reaches BLINK_DIV-1 it wraps to 0 and the blink phase toggles.
- Glyphs come from the standard hex table, active low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Digit i is blanked (seg=7'h7F) if either condition holds:
  - blank_lz=1, i>0, and shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked by the leading-zero rule.
  - blink_mask[i]=1 and blink phase=1.
- Outputs are registered, one cycle of latency from the counter/index state:
  - Scan counter < BLANK_CYC: an = all 1s, seg = 7'h7F.
  - Otherwise: an has bit index low, and seg is the glyph (or blank) for that index.
- blank_lz and blink_mask are sampled live, not double-buffered.
- Reset asserted mid-frame returns all state to reset values immediately. Scanning restarts at digit 0 with shadow=0.
- DIGITS=1: every slot wrap is a frame end.

Optional Feature:
- Macro: HEX_DISP_MUX_DP_EN.
- Defined:
  - Adds input dp_mask[DIGITS] and output dp (active low).
  - dp_mask is double-buffered alongside data (pending on load, shadow at frame end).
  - dp is low when shadow dp bit[index]=1 and the slot is outside the blank window.
  - dp is forced high when the digit is blink-blanked, but not when it is leading-zero blanked.
  - dp resets to 1.
- Undefined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Reset with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=2:
  - Required: seg=7'h7F, an=4'hF, frame=0 during reset.
  - Required: the first frame pulse arrives 16 cycles after release.
- load data=16'h12AF, then wait 2 frames:
  - Required: in each slot's non-blank cycles, an=4'hE/seg=7'h0E, an=4'hD/seg=7'h08, an=4'hB/seg=7'h24, an=4'h7/seg=7'h79.
  - Required: an=4'hF on the first cycle of every slot.
- Tear-free update: load 16'h0000 mid-frame while 16'h12AF is displayed:
  - Required: the current frame still shows 1,2,A,F.
  - Required: the next frame shows 0 on every digit (blank_lz=0).
- blank_lz=1, data=16'h0030:
  - Required: digits 3 and 2 show seg=7'h7F, digit 1 shows 7'h30, digit 0 shows 7'h40.
  - With data=16'h0000: digit 0 shows 7'h40 and the rest are blank.
- blink_mask=4'b0001:
  - Required: digit 0 is normal for 2 frames, then 7'h7F for 2 frames, repeating.
  - Required: the other digits are unaffected.
- Load coincident with frame end, and async reset mid-slot:
  - Required: the load value shows one frame later, not immediately.
  - Required: rst_n low mid-slot drives outputs to reset values within the same cycle, with no clock edge needed.
